md_unit_ctrl: RTL
=================

# md_unit_ctrl

Execute-stage multiply/divide sequencer for the pipelined MIPS core, sitting beside the ALU operand path. It accepts mult/multu/div/divu/mthi/mtlo commands from EX, runs the operation for a fixed multi-cycle latency, and holds the HI/LO architectural registers. It also generates the busy-driven stall that the hazard unit uses to freeze the pipeline whenever a later HI/LO instruction arrives during an operation.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high
- md_op  input  3  command valid this cycle: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- operand_a  input  32  rs value (dividend / multiplicand / mthi-mtlo source)
- operand_b  input  32  rt value (divisor / multiplier)
- md_use  input  1  instruction in D stage is any HI/LO instruction (mult..mtlo, mfhi, mflo)
- busy  output  1  operation in progress (registered)
- stall  output  1  combinational; md_use & (busy | start), where start = md_op in 001..100
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN. Down-counter cnt (4 bits) plus pending registers pend_hi/pend_lo.
- IDLE, md_op 001..100: sample operands, compute result into pend_hi/pend_lo, load cnt with MULT_CYCLES or DIV_CYCLES, go RUN. hi/lo unchanged.
- IDLE, md_op 101: hi <= operand_a. md_op 110: lo <= operand_a. Remain IDLE.
- RUN: cnt decrements each cycle; in the cycle cnt==1, hi<=pend_hi, lo<=pend_lo, go IDLE.
- RUN: every md_op value ignored (no restart, no mthi/mtlo write). The hazard unit guarantees none arrives; the bench checks that any that does is dropped.
- Arithmetic: mult = signed 32x32 -> 64, multu = unsigned; hi = product[63:32], lo = product[31:0].
- div: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend. divu: unsigned quotient/remainder.
- Divide by zero (operand_b==0, div or divu): runs full DIV_CYCLES latency, busy behaves normally, hi/lo left unchanged at completion.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- busy = (state==RUN).

## Timing
- Reset values: busy=0, hi=0, lo=0, state IDLE, cnt=0, pend_hi/pend_lo=0. stall follows its equation (0 with md_op=000 and md_use=0).
- Command issued in cycle T: busy high in cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES), new hi/lo visible from T+N+1, busy low at T+N+1.
- A new command may be issued in cycle T+N+1 (back-to-back).
- mthi/mtlo in cycle T: value visible on hi/lo at T+1; no busy.
- stall is high in cycle T itself if md_use=1, so a following mfhi/mflo never reads stale HI/LO.
- Reset asserted mid-RUN: next edge returns to IDLE, busy=0, hi=lo=0; pending result discarded, never committed.
- Reset and md_op both active in one cycle: reset wins; command lost.

## Test plan
- Reset then mult 0xFFFFFFFF x 0x00000002 at cycle T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div 0xFFFFFFF9 (-7) by 2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100 by 7 -> lo=14, hi=2.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive cycles -> hi/lo updated one cycle after each, busy stays 0; then div by 0 -> busy 10 cycles, hi/lo still 0x12345678/0x9ABCDEF0.
- Start mult, hold md_use=1 -> stall=1 from issue cycle through last busy cycle, 0 at T+6; issue mtlo 0x55 and divu mid-RUN -> both ignored, mult result committed unchanged.
- Back-to-back: mult completes, divu issued at T+6 -> busy continuous from T+7 for 10 cycles, correct results for both.
- Assert reset at 3rd busy cycle of div -> next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer with HI/LO registers.
// The result is computed when the command is accepted and parked in pend_hi/pend_lo.
// It is committed to HI/LO after a fixed busy latency.
// While busy, md_use raises stall so that no later HI/LO instruction observes stale state.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] pend_hi_reg, pend_hi_next;
  logic [31:0] pend_lo_reg, pend_lo_next;
  logic        pend_wr_reg, pend_wr_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  logic        start;
  logic        is_mult;
  logic        is_signed;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign start = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign busy  = (state_reg == RUN);
  assign stall = md_use & (busy | start);
  assign hi    = hi_reg;
  assign lo    = lo_reg;

  // Result datapath.
  // A single multiplier is used, with operands sign- or zero-extended to 64 bits.
  // Division works on magnitudes, and the signs are fixed afterwards.
  // This makes 0x80000000 / -1 come out as 0x80000000 rem 0 with no special case.
  always_comb begin
    is_mult   = (md_op == 3'd1) || (md_op == 3'd2);
    is_signed = (md_op == 3'd1) || (md_op == 3'd3);
    neg_a     = is_signed & operand_a[31];
    neg_b     = is_signed & operand_b[31];
    prod      = {{32{neg_a}}, operand_a} * {{32{neg_b}}, operand_b};
    a_mag     = neg_a ? (~operand_a + 32'd1) : operand_a;
    b_mag     = neg_b ? (~operand_b + 32'd1) : operand_b;
    b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_div;
    r_mag     = a_mag % b_div;
    if (is_mult) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
    end else begin
      res_hi = neg_a ? (~r_mag + 32'd1) : r_mag;
      res_lo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
      res_wr = (operand_b != 32'd0);   // divide by zero leaves HI/LO untouched
    end
  end

  // Next-state logic: accept a command or mthi/mtlo in IDLE.
  // In RUN, count down and commit on the last busy cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    pend_wr_next = pend_wr_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pend_hi_next = res_hi;
          pend_lo_next = res_lo;
          pend_wr_next = res_wr;
          cnt_next     = is_mult ? MULT_CNT : DIV_CNT;
          state_next   = RUN;
        end else if (md_op == 3'd5) begin
          hi_next = operand_a;
        end else if (md_op == 3'd6) begin
          lo_next = operand_a;
        end
      end
      RUN: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = IDLE;
          if (pend_wr_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
        end
      end
    endcase
  end

  // State register; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

endmodule
